// File: rtl/trace_replay_if.sv
// Bus bundle for the trace replay controller: host write port, trace stream
// towards the cache simulator, and the single trace SRAM port.
interface trace_replay_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;

    logic              trace_valid;
    logic              trace_ready;
    logic [DATA_W-1:0] trace_data;

    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    // Controller side
    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data,
        output host_wr_ready,
        output trace_valid, trace_data,
        input  trace_ready,
        output sram_csb, sram_web, sram_addr, sram_din,
        input  sram_dout
    );

    // Host / consumer / SRAM side
    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data,
        input  host_wr_ready,
        input  trace_valid, trace_data,
        output trace_ready,
        input  sram_csb, sram_web, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/trace_replay_ctrl.sv
// Trace replay controller: owns the trace SRAM port, accepts host writes while
// idle and replays trace_len words from address 0 onto a valid/ready stream.
module trace_replay_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    trace_replay_if.slave     bus,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   trace_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   replay_count
);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(1) << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   replay_cnt_q, replay_cnt_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_issue_q, rd_issue_d;   // read on the SRAM pins this cycle
    logic              rd_valid_q, rd_valid_d;   // sram_dout holds read data this cycle
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              fifo_empty, pop, pop_fifo, push, flush, wr_ready;
    logic [2:0]        occ;

    // Stream side: an empty FIFO lets the SRAM word straight through so that a
    // two-stage read pipeline still sustains one word per cycle with at most
    // two words buffered or in flight.
    assign fifo_empty      = (fifo_cnt_q == 2'd0);
    assign bus.trace_valid = !fifo_empty || rd_valid_q;
    assign bus.trace_data  = fifo_empty ? bus.sram_dout : fifo_mem_q[rd_ptr_q];
    assign pop             = bus.trace_valid && bus.trace_ready;
    assign pop_fifo        = pop && !fifo_empty;
    assign push            = rd_valid_q && !(fifo_empty && pop);
    assign occ             = 3'(fifo_cnt_q) + 3'(rd_issue_q) + 3'(rd_valid_q) - 3'(pop);
    assign flush           = abort && (state_q != S_IDLE);

    assign busy              = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done              = done_q;
    assign replay_count      = replay_cnt_q;
    assign bus.host_wr_ready = wr_ready;
    assign bus.sram_csb      = csb_q;
    assign bus.sram_web      = web_q;
    assign bus.sram_addr     = addr_q;
    assign bus.sram_din      = din_q;

    // Next-state, SRAM request and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        issue_cnt_d  = issue_cnt_q;
        replay_cnt_d = replay_cnt_q;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        addr_d       = addr_q;
        din_d        = din_q;
        rd_issue_d   = 1'b0;
        done_d       = 1'b0;
        wr_ready     = 1'b0;

        if (busy && pop && (replay_cnt_q < len_q))
            replay_cnt_d = replay_cnt_q + (ADDR_W+1)'(1);

        unique case (state_q)
            S_IDLE: begin
                wr_ready = !start && !reset;
                if (start) begin
                    len_d        = (trace_len > LEN_MAX) ? LEN_MAX : trace_len;
                    issue_cnt_d  = '0;
                    replay_cnt_d = '0;
                    state_d      = (trace_len == '0) ? S_DONE : S_READ;
                end else if (bus.host_wr_valid && wr_ready) begin
                    csb_d  = 1'b0;
                    web_d  = 1'b0;
                    addr_d = bus.host_wr_addr;
                    din_d  = bus.host_wr_data;
                end
            end
            S_READ: begin
                if (issue_cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else if (occ < 3'd2) begin
                    csb_d       = 1'b0;
                    web_d       = 1'b1;
                    addr_d      = issue_cnt_q[ADDR_W-1:0];
                    issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
                    rd_issue_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (replay_cnt_q == len_q)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            csb_d      = 1'b1;
            web_d      = 1'b1;
            rd_issue_d = 1'b0;
            done_d     = 1'b0;
        end

        rd_valid_d = rd_issue_q && !flush;
        fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop_fifo);
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop_fifo;
        if (flush) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end
    end

    // State and registered SRAM/stream control
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            issue_cnt_q  <= '0;
            replay_cnt_q <= '0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            addr_q       <= '0;
            din_q        <= '0;
            rd_issue_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            issue_cnt_q  <= issue_cnt_d;
            replay_cnt_q <= replay_cnt_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rd_issue_q   <= rd_issue_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // Output FIFO storage, written with the word returned by the SRAM
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= bus.sram_dout;
    end
endmodule

// File: tb/tb_trace_replay_ctrl.sv
// Scoreboard bench for trace_replay_ctrl with a behavioural 1-cycle SRAM.
module tb_trace_replay_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [AW:0]   trace_len;
    logic          busy, done;
    logic [AW:0]   replay_count;

    always #5 clk = ~clk;

    trace_replay_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    trace_replay_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .start        (start),
        .abort        (abort),
        .trace_len    (trace_len),
        .busy         (busy),
        .done         (done),
        .replay_count (replay_count)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mem [256];
    int unsigned   rd_hits [256];
    int unsigned   rd_base [256];
    int unsigned   sram_acc = 0;
    int unsigned   rd_iss = 0, acc_cnt = 0, wr_acc = 0, done_cnt = 0, wr_busy_seen = 0;
    int unsigned   acc_limit = 32'hFFFF_FFFF;
    int unsigned   iss0 = 0, acc0 = 0;
    int            max_os = 0;
    bit            track_os = 1'b0;
    int            rdy_mode = 0;
    bit            done_prev = 1'b0;
    bit            held_v = 1'b0;
    logic [DW-1:0] held_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nsample();
        @(negedge clk);
        #1;
    endtask

    // Behavioural single-port SRAM, one cycle read latency
    always @(posedge clk) begin
        if (!bus.sram_csb) begin
            sram_acc++;
            if (!bus.sram_web) begin
                mem[bus.sram_addr] <= bus.sram_din;
            end else begin
                bus.sram_dout <= mem[bus.sram_addr];
                rd_hits[bus.sram_addr]++;
            end
        end
    end

    // Consumer ready generator: low, high, or toggling, capped by acc_limit
    initial begin
        logic r;
        bus.trace_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                default: r = ~bus.trace_ready;
            endcase
            bus.trace_ready = r && (acc_cnt < acc_limit);
        end
    end

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (!bus.sram_csb && bus.sram_web) rd_iss++;
        if (bus.host_wr_valid && bus.host_wr_ready) begin
            wr_acc++;
            if (busy) wr_busy_seen++;
        end
        if (held_v && bus.trace_valid)
            chk("data_hold", bus.trace_data, held_d);
        held_v = bus.trace_valid && !bus.trace_ready;
        held_d = bus.trace_data;
        if (bus.trace_valid && bus.trace_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h, expected no word", bus.trace_data);
            end else begin
                chk("trace_data", bus.trace_data, exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            if (done_prev) begin
                tests++;
                fails++;
                $display("FAIL done_width: got done high 2 cycles, expected 1");
            end
        end
        done_prev = done;
        if (track_os && (int'((rd_iss - iss0) - (acc_cnt - acc0)) > max_os))
            max_os = int'((rd_iss - iss0) - (acc_cnt - acc0));
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        tick();
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = a;
        bus.host_wr_data  = d;
        for (int i = 0; i < 20; i++) begin
            nsample();
            if (bus.host_wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("host_write_timeout", 0, 1);
        tick();
        bus.host_wr_valid = 1'b0;
    endtask

    task automatic run_replay(input logic [AW:0] len, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
        tick();
        trace_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        nsample();
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int unsigned d0, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nsample();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic check_end(input string tag, input int unsigned d0, input logic [AW:0] cnt);
        repeat (3) nsample();
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_replay_count"}, replay_count, cnt);
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, a0, s0, w0, bad;
        bit ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0; trace_len = '0;
        bus.host_wr_valid = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        nsample();
        chk("rst_host_wr_ready", bus.host_wr_ready, 0);
        chk("rst_csb", bus.sram_csb, 1);
        chk("rst_web", bus.sram_web, 1);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_din", bus.sram_din, 0);
        chk("rst_trace_valid", bus.trace_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_replay_count", replay_count, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) host_write(AW'(i), 32'h1000 + DW'(i));

        // Basic replay, ready held high: 8 back-to-back accepts
        rdy_mode = 1;
        d0 = done_cnt; a0 = acc_cnt;
        run_replay(9'd8, 8, 32'h1000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
            nsample();
        end
        if (!ok) chk("first_word_timeout", 0, 1);
        repeat (7) nsample();
        chk("burst_accepts", acc_cnt - a0, 8);
        wait_done(d0, 50);
        check_end("basic", d0, 9'd8);

        // Same trace, ready toggling
        rdy_mode = 2;
        iss0 = rd_iss; acc0 = acc_cnt; track_os = 1'b1;
        d0 = done_cnt;
        run_replay(9'd8, 8, 32'h1000);
        wait_done(d0, 100);
        track_os = 1'b0;
        check_end("toggle", d0, 9'd8);
        chk("max_outstanding_le2", (max_os <= 2), 1);
        chk("toggle_reads", rd_iss - iss0, 8);

        // Zero-length replay
        rdy_mode = 1;
        d0 = done_cnt; s0 = sram_acc;
        tick();
        trace_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        nsample();
        chk("len0_done_early", done, 0);
        nsample();
        chk("len0_done", done, 1);
        check_end("len0", d0, 9'd0);
        chk("len0_sram_access", sram_acc - s0, 0);

        // start beats a same-cycle host write
        d0 = done_cnt; w0 = wr_acc;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000 + DW'(i));
        tick();
        trace_len = 9'd8;
        start = 1'b1;
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 8'd100;
        bus.host_wr_data  = 32'hBEEF;
        nsample();
        chk("start_wr_ready", bus.host_wr_ready, 0);
        tick();
        start = 1'b0;
        wait_done(d0, 50);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wr_acc != w0) begin
                ok = 1'b1;
                break;
            end
            nsample();
        end
        tick();
        bus.host_wr_valid = 1'b0;
        chk("wr_after_done", wr_acc - w0, 1);
        chk("wr_during_busy", wr_busy_seen, 0);
        check_end("startwr", d0, 9'd8);
        chk("wr_mem_100", mem[100], 32'hBEEF);

        // Abort after 3 words, then full restart
        d0 = done_cnt;
        acc_limit = acc_cnt + 3;
        run_replay(9'd8, 8, 32'h1000);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (acc_cnt == acc_limit) begin
                ok = 1'b1;
                break;
            end
            nsample();
        end
        if (!ok) chk("abort_wait_timeout", 0, 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nsample();
        chk("abort_trace_valid", bus.trace_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_csb", bus.sram_csb, 1);
        chk("abort_words_left", exp_q.size(), 5);
        exp_q.delete();
        acc_limit = 32'hFFFF_FFFF;
        repeat (5) nsample();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_trace_valid_late", bus.trace_valid, 0);
        chk("abort_replay_count", replay_count, 3);
        d0 = done_cnt;
        run_replay(9'd8, 8, 32'h1000);
        wait_done(d0, 50);
        check_end("restart", d0, 9'd8);

        // trace_len above capacity is clamped to 256
        for (int i = 0; i < 256; i++) host_write(AW'(i), 32'hA500_0000 + DW'(i));
        for (int i = 0; i < 256; i++) rd_base[i] = rd_hits[i];
        d0 = done_cnt; a0 = acc_cnt;
        run_replay(9'd300, 256, 32'hA500_0000);
        wait_done(d0, 1000);
        check_end("clamp", d0, 9'd256);
        chk("clamp_accepts", acc_cnt - a0, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (rd_hits[i] - rd_base[i] != 1) bad++;
        chk("clamp_addr_read_once", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
